// File: rtl/miner_pkg.sv
// Shared miner definitions: widths, digest/nonce types and compare helpers.
package miner_pkg;

  localparam int DIGEST_BITS = 256;
  localparam int NONCE_BITS  = 32;
  localparam int WORD_BITS   = 32;

  typedef logic [NONCE_BITS-1:0]  nonce_t;
  typedef logic [DIGEST_BITS-1:0] digest_t;

  // Half-width compare results registered between the two compare stages.
  typedef struct packed {
    logic hi_lt;
    logic hi_eq;
    logic lo_lt;
  } cmp_flags_t;

  // Recombine half-width flags into a full unsigned strict less-than.
  function automatic logic cmp_hit(input cmp_flags_t f);
    return f.hi_lt | (f.hi_eq & f.lo_lt);
  endfunction

endpackage

// File: rtl/share_fifo.sv
// Synchronous FIFO for winning nonces; clear flushes it in one cycle.
module share_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             pop_en, push_en;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_en  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a push on full still lands.
  assign push_en = push & (~full | pop_en);
  // Head reads as zero when empty so the output is clean after reset/clear.
  assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer update; clear wins over any push/pop in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents are don't-care until the pointers expose them.
  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/share_checker.sv
// Tags encrypt digests with nonces, compares against the target in two
// stages and queues winning nonces for the host.
module share_checker
  import miner_pkg::*;
#(
  parameter int DIGEST_BITS = miner_pkg::DIGEST_BITS,
  parameter int NONCE_BITS  = miner_pkg::NONCE_BITS,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [NONCE_BITS-1:0]  nonce_base,
  input  logic [DIGEST_BITS-1:0] target,
  input  logic [DIGEST_BITS-1:0] in_digest,
  input  logic                   in_write,
  output logic                   found_valid,
  output logic [NONCE_BITS-1:0]  found_nonce,
  input  logic                   found_ready,
  output logic [NONCE_BITS-1:0]  checked_count,
  output logic                   overflow
);

  localparam int HALF   = DIGEST_BITS / 2;
  localparam int STAGES = 1;

  logic [DIGEST_BITS-1:0] target_q;
  logic [NONCE_BITS-1:0]  nonce_ctr;
  logic [NONCE_BITS-1:0]  s1_nonce;
  cmp_flags_t             s1_flags, cmp_d;
  logic [STAGES:1]        vld_pipe;
  logic                   acc, hit, push, pop, full, empty, drop;

  // A write coinciding with start belongs to the old job and is discarded.
  assign acc = in_write & ~start;

  assign cmp_d.hi_lt = in_digest[DIGEST_BITS-1:HALF] <  target_q[DIGEST_BITS-1:HALF];
  assign cmp_d.hi_eq = in_digest[DIGEST_BITS-1:HALF] == target_q[DIGEST_BITS-1:HALF];
  assign cmp_d.lo_lt = in_digest[HALF-1:0]           <  target_q[HALF-1:0];

  assign hit  = vld_pipe[1] & cmp_hit(s1_flags);
  assign push = hit & ~start;
  assign pop  = found_valid & found_ready;
  assign drop = push & full & ~pop;

  assign found_valid = ~empty;

  // Job setup and nonce/count bookkeeping for accepted digests.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target_q      <= '0;
      nonce_ctr     <= '0;
      checked_count <= '0;
    end else if (start) begin
      target_q      <= target;
      nonce_ctr     <= nonce_base;
      checked_count <= '0;
    end else if (in_write) begin
      nonce_ctr     <= nonce_ctr + 1'b1;
      checked_count <= checked_count + 1'b1;
    end
  end

  // Stage 1: half-width compare flags plus nonce tag; start kills in-flight work.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      s1_flags <= '0;
      s1_nonce <= '0;
    end else begin
      vld_pipe[1] <= acc;
      s1_flags    <= cmp_d;
      s1_nonce    <= nonce_ctr;
    end
  end

  // Sticky overflow when a winning nonce finds no room.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        overflow <= 1'b0;
    else if (start) overflow <= 1'b0;
    else if (drop)  overflow <= 1'b1;
  end

  share_fifo #(
    .WIDTH (NONCE_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (start),
    .push  (push),
    .din   (s1_nonce),
    .pop   (pop),
    .dout  (found_nonce),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_share_checker.sv
// Directed bench for share_checker: reset, hit tagging, compare boundaries,
// overflow, full-with-pop, start collision and nonce wrap.
module tb_share_checker;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [31:0]  nonce_base;
  logic [255:0] target;
  logic [255:0] in_digest;
  logic         in_write;
  logic         found_valid;
  logic [31:0]  found_nonce;
  logic         found_ready;
  logic [31:0]  checked_count;
  logic         overflow;

  int checks = 0;
  int errors = 0;

  localparam logic [255:0] ONES = {256{1'b1}};

  share_checker dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .nonce_base    (nonce_base),
    .target        (target),
    .in_digest     (in_digest),
    .in_write      (in_write),
    .found_valid   (found_valid),
    .found_nonce   (found_nonce),
    .found_ready   (found_ready),
    .checked_count (checked_count),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic do_start(input logic [31:0] base, input logic [255:0] tgt);
    start = 1'b1; nonce_base = base; target = tgt;
    step();
    start = 1'b0;
  endtask

  task automatic wr(input logic [255:0] d);
    in_write = 1'b1; in_digest = d;
    step();
    in_write = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(2);
    checks++;
    if ({found_valid, found_nonce, checked_count, overflow} !== 65'd0) begin
      errors++;
      $display("FAIL reset_state: got v=%0b n=%h c=%0d o=%0b, want all 0",
               found_valid, found_nonce, checked_count, overflow);
    end
    rst = 1'b0;
    step();
    do_start(32'h55, ONES);
    wr('0); wr('0); wr('0);
    idle(1);
    rst = 1'b1;
    step();
    checks++;
    if ({found_valid, found_nonce, checked_count, overflow} !== 65'd0) begin
      errors++;
      $display("FAIL reset_mid: got v=%0b n=%h c=%0d o=%0b, want all 0",
               found_valid, found_nonce, checked_count, overflow);
    end
    rst = 1'b0;
    step();
    wr('0);
    idle(3);
    checks++;
    if (found_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_target: found_valid=%0b want 0", found_valid);
    end
    checks++;
    if (checked_count !== 32'd1) begin
      errors++;
      $display("FAIL reset_count: checked_count=%0d want 1", checked_count);
    end
  endtask

  task automatic test_single_hit();
    do_start(32'h100, {32'h0000FFFF, 224'h0});
    wr(ONES);
    wr({32'h1, 224'h0});
    checks++;
    if (found_valid !== 1'b0) begin
      errors++;
      $display("FAIL hit_early: found_valid=%0b one cycle after hit, want 0", found_valid);
    end
    wr(ONES);
    checks++;
    if (found_valid !== 1'b1 || found_nonce !== 32'h101) begin
      errors++;
      $display("FAIL hit_entry: v=%0b nonce=%h want v=1 nonce=00000101", found_valid, found_nonce);
    end
    checks++;
    if (checked_count !== 32'd3) begin
      errors++;
      $display("FAIL hit_count: checked_count=%0d want 3", checked_count);
    end
    found_ready = 1'b1;
    step();
    found_ready = 1'b0;
    idle(3);
    checks++;
    if (found_valid !== 1'b0) begin
      errors++;
      $display("FAIL hit_only_one: found_valid=%0b want 0", found_valid);
    end
  endtask

  task automatic test_equality();
    logic [255:0] t;
    t = {128'h5, 128'h10};
    do_start(32'h200, t);
    wr(t);
    idle(3);
    checks++;
    if (found_valid !== 1'b0) begin
      errors++;
      $display("FAIL eq_no_hit: found_valid=%0b want 0", found_valid);
    end
    wr({128'h5, 128'hF});
    idle(1);
    checks++;
    if (found_valid !== 1'b1 || found_nonce !== 32'h201) begin
      errors++;
      $display("FAIL eq_lo_less: v=%0b nonce=%h want v=1 nonce=00000201", found_valid, found_nonce);
    end
    found_ready = 1'b1; step(); found_ready = 1'b0;
    t = {128'h1, 128'h0};
    do_start(32'h300, t);
    wr({128'h0, {128{1'b1}}});
    idle(1);
    checks++;
    if (found_valid !== 1'b1 || found_nonce !== 32'h300) begin
      errors++;
      $display("FAIL eq_minus_one: v=%0b nonce=%h want v=1 nonce=00000300", found_valid, found_nonce);
    end
    found_ready = 1'b1; step(); found_ready = 1'b0;
  endtask

  task automatic test_overflow();
    do_start(32'h20, ONES);
    for (int i = 0; i < 6; i++) wr('0);
    idle(2);
    checks++;
    if (overflow !== 1'b1 || checked_count !== 32'd6) begin
      errors++;
      $display("FAIL ovf_set: overflow=%0b count=%0d want 1 and 6", overflow, checked_count);
    end
    found_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (found_valid !== 1'b1 || found_nonce !== 32'h20 + i) begin
        errors++;
        $display("FAIL ovf_pop%0d: v=%0b nonce=%h want v=1 nonce=%h",
                 i, found_valid, found_nonce, 32'h20 + i);
      end
      step();
    end
    found_ready = 1'b0;
    checks++;
    if (found_valid !== 1'b0 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_drained: v=%0b overflow=%0b want 0 and 1", found_valid, overflow);
    end
  endtask

  task automatic test_full_pop();
    do_start(32'h40, ONES);
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL start_clears_ovf: overflow=%0b want 0", overflow);
    end
    for (int i = 0; i < 5; i++) wr('0);
    checks++;
    if (found_valid !== 1'b1 || found_nonce !== 32'h40) begin
      errors++;
      $display("FAIL full_head: v=%0b nonce=%h want v=1 nonce=00000040", found_valid, found_nonce);
    end
    found_ready = 1'b1;
    step();
    found_ready = 1'b0;
    idle(1);
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL full_pop_ovf: overflow=%0b want 0", overflow);
    end
    found_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (found_valid !== 1'b1 || found_nonce !== 32'h41 + i) begin
        errors++;
        $display("FAIL full_pop_order%0d: v=%0b nonce=%h want v=1 nonce=%h",
                 i, found_valid, found_nonce, 32'h41 + i);
      end
      step();
    end
    found_ready = 1'b0;
    checks++;
    if (found_valid !== 1'b0) begin
      errors++;
      $display("FAIL full_pop_empty: found_valid=%0b want 0", found_valid);
    end
  endtask

  task automatic test_start_collision();
    do_start(32'h60, ONES);
    wr('0);
    wr('0);
    start = 1'b1; nonce_base = 32'h80; target = ONES;
    in_write = 1'b1; in_digest = '0;
    step();
    start = 1'b0; in_write = 1'b0;
    checks++;
    if (found_valid !== 1'b0 || checked_count !== 32'd0) begin
      errors++;
      $display("FAIL coll_flush: v=%0b count=%0d want 0 and 0", found_valid, checked_count);
    end
    idle(3);
    checks++;
    if (found_valid !== 1'b0) begin
      errors++;
      $display("FAIL coll_no_late: found_valid=%0b want 0", found_valid);
    end
    wr('0);
    idle(1);
    checks++;
    if (found_valid !== 1'b1 || found_nonce !== 32'h80 || checked_count !== 32'd1) begin
      errors++;
      $display("FAIL coll_next: v=%0b nonce=%h count=%0d want 1 00000080 1",
               found_valid, found_nonce, checked_count);
    end
    found_ready = 1'b1; step(); found_ready = 1'b0;
  endtask

  task automatic test_wrap();
    do_start(32'hFFFF_FFFF, ONES);
    wr('0);
    wr('0);
    checks++;
    if (found_valid !== 1'b1 || found_nonce !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL wrap_first: v=%0b nonce=%h want v=1 nonce=ffffffff", found_valid, found_nonce);
    end
    found_ready = 1'b1;
    step();
    checks++;
    if (found_valid !== 1'b1 || found_nonce !== 32'h0 || checked_count !== 32'd2) begin
      errors++;
      $display("FAIL wrap_second: v=%0b nonce=%h count=%0d want 1 00000000 2",
               found_valid, found_nonce, checked_count);
    end
    step();
    found_ready = 1'b0;
    checks++;
    if (found_valid !== 1'b0) begin
      errors++;
      $display("FAIL wrap_empty: found_valid=%0b want 0", found_valid);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; nonce_base = '0; target = '0;
    in_digest = '0; in_write = 1'b0; found_ready = 1'b0;
    test_reset();
    test_single_hit();
    test_equality();
    test_overflow();
    test_full_pop();
    test_start_collision();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/share_checker.md
# share_checker

Downstream consumer of the `encrypt` stage. It accepts one 256-bit digest per `in_write` strobe and tags each digest with its nonce. A two-stage registered compare checks the digest against a host-loaded target, and the nonces of winning digests are queued in a small FIFO. The host drains the FIFO over a valid/ready handshake. `encrypt` has no backpressure, so this block never stalls its input.

## Interface
Parameters:
- `DIGEST_BITS`, 256: digest and target width.
- `NONCE_BITS`, 32: nonce and counter width.
- `FIFO_DEPTH`, 4: winning-nonce queue depth; power of two, ≥2.

Ports:
- `clk`, in, 1: single clock; all logic on its rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: pulse; loads `target`/`nonce_base`, flushes pipeline, FIFO, counters and `overflow`.
- `nonce_base`, in, NONCE_BITS: nonce of the first digest after `start`.
- `target`, in, DIGEST_BITS: share threshold, sampled only on `start`.
- `in_digest`, in, DIGEST_BITS: digest from `encrypt`; bits [255:224] most significant.
- `in_write`, in, 1: `in_digest` valid this cycle.
- `found_valid`, out, 1: FIFO head valid.
- `found_nonce`, out, NONCE_BITS: FIFO head nonce.
- `found_ready`, in, 1: host pops head when `found_valid & found_ready`.
- `checked_count`, out, NONCE_BITS: digests accepted since `start`.
- `overflow`, out, 1: sticky; a hit was dropped because the FIFO was full.

## Operation
- **Nonce tagging.**
  - `nonce_ctr` is loaded with `nonce_base` on `start`.
  - Each accepted `in_write` tags the digest with the current `nonce_ctr`, then increments `nonce_ctr` and `checked_count`.
  - Both counters wrap modulo 2^NONCE_BITS.
- **Compare.** Unsigned, strict: hit ⇔ `in_digest < target_q`.
  - Stage 1 registers `hi_lt`, `hi_eq` (bits [255:128]) and `lo_lt` (bits [127:0]), plus the nonce tag and valid bit.
  - Stage 2 forms `hit = hi_lt | (hi_eq & lo_lt)` and pushes the nonce if the stage-2 valid bit is set.
- **FIFO.**
  - Push on hit when not full.
  - Push on full with a simultaneous pop is accepted.
  - Push on full without a pop drops the entry and sets `overflow`.
  - Pop on empty is ignored.
  - Simultaneous push and pop while non-empty keeps the count unchanged.
- **Start.** `start` overrides everything in the same cycle:
  - an `in_write` in the start cycle is discarded and not counted;
  - stage-1/2 valid bits are cleared, so in-flight hits are lost;
  - FIFO pointers are cleared, `checked_count` and `overflow` are cleared;
  - `target_q` and `nonce_ctr` are loaded.
- **Reset (`rst`).**
  - All valids, pointers and counters are 0; `target_q` = 0, so no hits until the first `start`.
  - Output reset values: `found_valid` 0, `found_nonce` 0, `checked_count` 0, `overflow` 0.
  - Reset mid-operation discards all state immediately.

## Timing
- For an `in_write` in cycle t:
  - stage-1 registers load at the end of t;
  - the FIFO write occurs at the end of t+1;
  - `found_valid` rises in cycle t+2 if the FIFO was empty. There is no bypass.
- `checked_count` reflects the write in cycle t+1.
- Back-to-back `in_write` is sustained at 1 digest/cycle.
- `found_nonce` is stable while `found_valid & ~found_ready`.
- After a pop in cycle c, the next entry, if any, is presented in c+1.
- `overflow` rises the cycle after the dropping push and holds until `start` or `rst`.
- `start` in cycle s: the first digest counted is one written in s+1 or later, and it is tagged `nonce_base`.

## Structure
- Shared package `miner_pkg` holds `DIGEST_BITS`, `NONCE_BITS`, `WORD_BITS` and the `nonce_t`/`digest_t` typedefs. The `encrypt` path uses the same package.
- Sub-module `share_fifo`:
  - synchronous FIFO, width NONCE_BITS, depth FIFO_DEPTH;
  - push/pop/full/empty ports plus a `clear` input driven by `start`;
  - uses `rst`.
- Top level contains the nonce counter, the two compare stages and the overflow/count logic.

## Test plan
- **Reset:** `rst` mid-stream → all outputs 0 the next cycle. After release with no `start`, digest 0 → no hit, because target is 0.
- **Single hit:**
  - Stimulus: `start` with base 0x100, target 0x0000_FFFF<<224. Write digests D0 = all-ones, D1 = 0x0000_0001<<224, D2 = all-ones on consecutive cycles.
  - Response: exactly one entry, nonce 0x101, `found_valid` two cycles after D1; `checked_count` = 3.
- **Equality boundary:**
  - Stimulus: digest == target.
  - Response: no hit.
  - Stimulus: digest = target−1, and target with hi halves equal and lo less.
  - Response: hit.
- **Overflow:**
  - Stimulus: target all-ones, `found_ready` = 0, 6 writes.
  - Response: 4 entries with nonces base..base+3; `overflow` = 1.
  - Stimulus: set `found_ready` = 1.
  - Response: pops in order, then `found_valid` = 0.
- **Full with simultaneous pop:** FIFO full, pop and hit in the same cycle → no overflow; count stays 4; the new nonce lands last.
- **Start collision:**
  - Stimulus: `start` in the same cycle as an `in_write`, with two hits in flight.
  - Response: no entries from either; `checked_count` = 0; the next write is tagged with the new `nonce_base`.
- **Nonce wrap:** base 0xFFFF_FFFF, two hits → nonces 0xFFFF_FFFF, 0x0000_0000.
